// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy game blocks: draw FSM states and
// maximal-length Galois LFSR feedback masks (right-shift form) per width.
package flappy_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;

    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [31:0] TAPS_W32 = 32'hA3000000;

endpackage

// File: rtl/lfsr_core.sv
// Right-shift Galois LFSR with seed load; a zero seed is replaced by SEED so
// the register can never lock up in the all-zero state.
module lfsr_core #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_step;

    always_comb begin
        q_step = (q >> 1) ^ (q[0] ? TAPS : '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (load) begin
            q <= (d == '0) ? SEED : d;
        end else if (en) begin
            q <= q_step;
        end
    end

endmodule

// File: rtl/pipe_rand_gen.sv
// Range-limited random draw: bounded rejection sampling over a free-running LFSR,
// falling back to a halved candidate after MAX_TRIES rejected attempts.
module pipe_rand_gen
    import flappy_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = TAPS_W8,
    parameter logic [WIDTH-1:0] SEED      = 8'h01,
    parameter int               OUT_W     = 8,
    parameter int               MAX_TRIES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    input  logic [OUT_W-1:0] lo,
    input  logic [OUT_W-1:0] hi,
    output logic             busy,
    output logic             valid,
    output logic [OUT_W-1:0] out,
    output logic             fallback,
    output logic [WIDTH-1:0] raw,
    output state_t           dbg_state
);

    localparam int TW = $clog2(MAX_TRIES + 1);

    // Handshake: req is taken only while busy=0 (IDLE) and never queued; valid is a
    // one-cycle pulse with out/fallback updated, and there is no back-pressure.
    state_t           state, state_next;
    logic [TW-1:0]    tries;
    logic [OUT_W-1:0] lo_l, span_l, span_in, mask, cand;
    logic             hit, last, accept, finish, step_try;

    lfsr_core #(.WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .load  (seed_load),
        .d     (seed_in),
        .q     (raw)
    );

    // Inverted bounds collapse to an empty span so the result is lo.
    always_comb begin
        span_in = (hi < lo) ? '0 : (hi - lo);
    end

    always_comb begin
        mask = span_l;
        for (int i = 1; i < OUT_W; i++) begin
            mask = mask | (span_l >> i);
        end
    end

    always_comb begin
        cand = raw[OUT_W-1:0] & mask;
        hit  = (cand <= span_l);
        last = (tries == TW'(MAX_TRIES - 1));
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        step_try   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    state_next = DRAW;
                end
            end
            DRAW: begin
                if (en) begin
                    if (hit || last) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        step_try = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            tries    <= '0;
            lo_l     <= '0;
            span_l   <= '0;
            out      <= '0;
            valid    <= 1'b0;
            fallback <= 1'b0;
        end else begin
            state <= state_next;
            valid <= finish;
            if (accept) begin
                lo_l   <= lo;
                span_l <= span_in;
                tries  <= '0;
            end
            if (step_try) begin
                tries <= tries + 1'b1;
            end
            // mask < 2*span+1 keeps cand>>1 within span, so both paths stay in range.
            if (finish) begin
                out      <= hit ? (lo_l + cand) : (lo_l + (cand >> 1));
                fallback <= ~hit;
            end
        end
    end

    assign busy      = (state == DRAW);
    assign dbg_state = state;

endmodule
